alu_sequencer: RTL and testbench

- Multi-cycle control FSM that fetches one 10-bit instruction word and sequences the shared ALU and the eight-entry register bus for it.
- Drives the ALU's operand-latch enables (`Ain`, `Gin`), compute enable (`Gout`) and function code (`FN`).
- Also drives the bus source/destination selects for the register file, the external data input and the ALU result.
- Sits between the instruction source (start/done handshake) and the datapath; one instruction in flight at a time.

---
 rtl/alu_sequencer.sv | 145 ++++++++++++++
 tb/tb_alu_sequencer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Multi-cycle control FSM issuing ALU and register-bus controls for one 10-bit instruction at a time.
// Optional macro ALU_SEQ_ILLEGAL_TRAP_EN: illegal opcodes lock into TRAP until reset instead of acting as NOPs.
module alu_sequencer #(
  parameter int unsigned NREG = 8
) (
  input  logic            CLKb,
  input  logic            Resetn,
  input  logic            Start,
  input  logic [9:0]      INSTR,
  output logic            Busy,
  output logic            Done,
  output logic            Err,
  output logic [3:0]      FN,
  output logic            Ain,
  output logic            Gin,
  output logic            Gout,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic            DinOut,
  output logic            QOut
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T1   = 3'd1;
  localparam logic [2:0] S_T2   = 3'd2;
  localparam logic [2:0] S_T3   = 3'd3;
  localparam logic [2:0] S_T4   = 3'd4;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  localparam logic [2:0] S_TRAP = 3'd5;
`endif

  localparam logic [3:0] OP_LD = 4'b0000;
  localparam logic [3:0] OP_MV = 4'b0001;

  logic [2:0] state_q, state_d;
  logic [9:0] ir_q, ir_d;
  logic [3:0] op;
  logic [2:0] rx, ry;

  function automatic logic is_binary(input logic [3:0] opc);
    return (opc inside {4'b0010, 4'b0011, [4'b0110:4'b1011]});
  endfunction

  function automatic logic is_unary(input logic [3:0] opc);
    return (opc == 4'b0100) || (opc == 4'b0101);
  endfunction

  function automatic logic is_illegal(input logic [3:0] opc);
    return (opc[3:2] == 2'b11);
  endfunction

  function automatic logic [NREG-1:0] onehot(input logic [2:0] idx);
    logic [NREG-1:0] v;
    for (int unsigned i = 0; i < NREG; i++) v[i] = (i == 32'(idx));
    return v;
  endfunction

  assign op = ir_q[9:6];
  assign rx = ir_q[5:3];
  assign ry = ir_q[2:0];

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          ir_d = INSTR;
          // Unary ops skip operand-A load and start directly at T2.
          if (is_unary(INSTR[9:6])) state_d = S_T2;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
          else if (is_illegal(INSTR[9:6])) state_d = S_TRAP;
`endif
          else state_d = S_T1;
        end
      end
      S_T1:    state_d = is_binary(op) ? S_T2 : S_IDLE;
      S_T2:    state_d = S_T3;
      S_T3:    state_d = S_T4;
      S_T4:    state_d = S_IDLE;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      S_TRAP:  state_d = S_TRAP;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLKb) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    Busy   = (state_q != S_IDLE);
    FN     = Busy ? op : 4'b0000;
    Done   = 1'b0;
    Err    = 1'b0;
    Ain    = 1'b0;
    Gin    = 1'b0;
    Gout   = 1'b0;
    Rin    = '0;
    Rout   = '0;
    DinOut = 1'b0;
    QOut   = 1'b0;
    case (state_q)
      S_T1: begin
        if (op == OP_LD) begin
          DinOut = 1'b1;
          Rin    = onehot(rx);
          Done   = 1'b1;
        end else if (op == OP_MV) begin
          Rout = onehot(ry);
          Rin  = onehot(rx);
          Done = 1'b1;
        end else if (is_binary(op)) begin
          Rout = onehot(rx);
          Ain  = 1'b1;
        end else if (is_illegal(op)) begin
          Done = 1'b1;
          Err  = 1'b1;
        end
      end
      S_T2: begin
        Rout = onehot(ry);
        Gin  = 1'b1;
      end
      S_T3: Gout = 1'b1;
      S_T4: begin
        QOut = 1'b1;
        Rin  = onehot(rx);
        Done = 1'b1;
      end
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      S_TRAP: Err = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer; compares the full output vector after each clock edge.
module tb_alu_sequencer;

  logic       CLKb = 1'b0;
  logic       Resetn;
  logic       Start;
  logic [9:0] INSTR;
  logic       Busy, Done, Err, Ain, Gin, Gout, DinOut, QOut;
  logic [3:0] FN;
  logic [7:0] Rin, Rout;
  logic [27:0] obs;

  int checks = 0;
  int failures = 0;

  alu_sequencer #(.NREG(8)) dut (
    .CLKb(CLKb), .Resetn(Resetn), .Start(Start), .INSTR(INSTR),
    .Busy(Busy), .Done(Done), .Err(Err), .FN(FN),
    .Ain(Ain), .Gin(Gin), .Gout(Gout), .Rin(Rin), .Rout(Rout),
    .DinOut(DinOut), .QOut(QOut)
  );

  always #5 CLKb = ~CLKb;

  assign obs = {Busy, Done, Err, FN, Ain, Gin, Gout, Rin, Rout, DinOut, QOut};

  function automatic logic [27:0] ev(input logic busy, input logic done, input logic err,
                                     input logic [3:0] fn, input logic ain, input logic gin,
                                     input logic gout, input logic [7:0] rin, input logic [7:0] rout,
                                     input logic din, input logic q);
    return {busy, done, err, fn, ain, gin, gout, rin, rout, din, q};
  endfunction

  localparam logic [27:0] IDLE_V = 28'h0;

  task automatic tick();
    @(posedge CLKb);
    #1;
  endtask

  task automatic chk(input string tag, input logic [27:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    Resetn = 1'b0;
    Start  = 1'b1;
    INSTR  = 10'b0010_011_101;
    tick(); chk("reset_c1", IDLE_V);
    tick(); chk("reset_c2", IDLE_V);

    // add R3,R5
    Resetn = 1'b1;
    tick(); Start = 1'b0;
    chk("add_t1", ev(1,0,0,4'h2,1,0,0,8'h00,8'h08,0,0));
    tick(); chk("add_t2", ev(1,0,0,4'h2,0,1,0,8'h00,8'h20,0,0));
    tick(); chk("add_t3", ev(1,0,0,4'h2,0,0,1,8'h00,8'h00,0,0));
    tick(); chk("add_t4", ev(1,1,0,4'h2,0,0,0,8'h08,8'h00,0,1));
    tick(); chk("add_idle", IDLE_V);

    // inv R1,R6 issued in the cycle right after Done
    Start = 1'b1; INSTR = 10'b0100_001_110;
    tick(); Start = 1'b0;
    chk("inv_t2", ev(1,0,0,4'h4,0,1,0,8'h00,8'h40,0,0));
    tick(); chk("inv_t3", ev(1,0,0,4'h4,0,0,1,8'h00,8'h00,0,0));
    tick(); chk("inv_t4", ev(1,1,0,4'h4,0,0,0,8'h02,8'h00,0,1));
    tick(); chk("inv_idle", IDLE_V);

    // ld R7 then mv R2,R7 back-to-back; Start held high through ld's T1
    Start = 1'b1; INSTR = 10'b0000_111_000;
    tick(); INSTR = 10'b0001_010_111;
    chk("ld_t1", ev(1,1,0,4'h0,0,0,0,8'h80,8'h00,1,0));
    tick(); chk("ld_idle", IDLE_V);
    tick(); Start = 1'b0;
    chk("mv_t1", ev(1,1,0,4'h1,0,0,0,8'h04,8'h80,0,0));
    tick(); chk("mv_idle", IDLE_V);

    // mv R4,R4 (same source and destination)
    Start = 1'b1; INSTR = 10'b0001_100_100;
    tick(); Start = 1'b0;
    chk("mv_same", ev(1,1,0,4'h1,0,0,0,8'h10,8'h10,0,0));
    tick(); chk("mv_same_idle", IDLE_V);

    // sub R0,R1 with a foreign Start during T2
    Start = 1'b1; INSTR = 10'b0011_000_001;
    tick(); Start = 1'b0;
    chk("sub_t1", ev(1,0,0,4'h3,1,0,0,8'h00,8'h01,0,0));
    tick(); Start = 1'b1; INSTR = 10'b0001_111_111;
    chk("sub_t2", ev(1,0,0,4'h3,0,1,0,8'h00,8'h02,0,0));
    tick(); Start = 1'b0;
    chk("sub_t3", ev(1,0,0,4'h3,0,0,1,8'h00,8'h00,0,0));
    tick(); chk("sub_t4", ev(1,1,0,4'h3,0,0,0,8'h01,8'h00,0,1));
    tick(); chk("sub_idle", IDLE_V);
    tick(); chk("sub_no_queue", IDLE_V);

    // illegal opcode 1110
    Start = 1'b1; INSTR = 10'b1110_000_000;
    tick(); Start = 1'b0;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    for (int i = 0; i < 12; i++) begin
      chk("trap_hold", ev(1,0,1,4'hE,0,0,0,8'h00,8'h00,0,0));
      Start = i[0];
      INSTR = 10'b0000_001_000;
      tick();
    end
    Start = 1'b0;
    Resetn = 1'b0;
    tick(); chk("trap_reset", IDLE_V);
    Resetn = 1'b1;
    tick(); chk("trap_after", IDLE_V);
`else
    chk("illegal_t1", ev(1,1,1,4'hE,0,0,0,8'h00,8'h00,0,0));
    tick(); chk("illegal_idle", IDLE_V);
`endif

    // reset during T3 of add R3,R5
    Start = 1'b1; INSTR = 10'b0010_011_101;
    tick(); Start = 1'b0;
    chk("abort_t1", ev(1,0,0,4'h2,1,0,0,8'h00,8'h08,0,0));
    tick(); tick();
    chk("abort_t3", ev(1,0,0,4'h2,0,0,1,8'h00,8'h00,0,0));
    Resetn = 1'b0;
    tick(); chk("abort_reset", IDLE_V);
    Resetn = 1'b1;
    tick(); chk("abort_no_done", IDLE_V);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
